// File: rtl/agc_seq_pkg.sv
// Shared types and constants for the AGC loop sequencer.
// State encoding, PWM step codes and the absolute power-error helper.
package agc_seq_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StSettle  = 3'd1,
        StMeasure = 3'd2,
        StWaitUpd = 3'd3,
        StLocked  = 3'd4,
        StTrkMeas = 3'd5,
        StFail    = 3'd6
    } agc_state_e;

    localparam logic [1:0] STEP_COARSE = 2'd3;
    localparam logic [1:0] STEP_MED    = 2'd2;
    localparam logic [1:0] STEP_FINE   = 2'd1;

    localparam int unsigned PWR_W = 9;
    localparam int unsigned ERR_W = 9;

    // 10-bit signed difference of two unsigned 9-bit powers; magnitude always fits 9 bits.
    function automatic logic [ERR_W-1:0] abs_err(input logic [PWR_W-1:0] a,
                                                 input logic [PWR_W-1:0] b);
        logic signed [PWR_W:0] diff;
        diff = $signed({1'b0, a}) - $signed({1'b0, b});
        return diff[PWR_W] ? ERR_W'(-diff) : ERR_W'(diff);
    endfunction

endpackage

// File: rtl/agc_dly_cnt.sv
// Loadable down counter with a zero flag; stops at zero.
// Used for settle delay, tracking period and the shared watchdog.
module agc_dly_cnt #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             dec_i,
    output logic             zero_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - Width'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/agc_loop_seq.sv
// AGC gain-loop sequencer: settle, measure, wait for PWM update, coarse-to-fine stepping.
// Define AGC_TRACK_EN to enable post-lock tracking with periodic re-measurement and relock.
module agc_loop_seq
    import agc_seq_pkg::*;
#(
    parameter int unsigned SETTLE_W     = 12,
    parameter int unsigned TRACK_W      = 16,
    parameter int unsigned ITER_W       = 6,
    parameter int unsigned COARSE_ITERS = 8,
    parameter int unsigned MED_ITERS    = 16,
    parameter int unsigned MAX_ITERS    = 48,
    parameter int unsigned EST_TO       = 1023,
    parameter int unsigned UPD_TO       = 4
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                agc_start_i,
    input  logic                agc_stop_i,
    input  logic [SETTLE_W-1:0] settle_cyc_i,
    input  logic [TRACK_W-1:0]  track_period_i,
    input  logic [PWR_W-1:0]    relock_th_i,
    input  logic [PWR_W-1:0]    pwr_req_val_i,
    input  logic [PWR_W-1:0]    pwr_est_db_i,
    input  logic                pwr_est_end_i,
    input  logic                pwm_val_up_i,
    input  logic                agc_fix_i,
    output logic                est_start_o,
    output logic                pwm_ena_o,
    output logic [1:0]          pwm_step_o,
    output logic                agc_busy_o,
    output logic                agc_locked_o,
    output logic                agc_fail_o,
    output logic                agc_relock_o,
    output logic [ITER_W-1:0]   iter_cnt_o
);

    localparam int unsigned WdMax = (EST_TO > UPD_TO) ? EST_TO : UPD_TO;
    localparam int unsigned WdW   = $clog2(WdMax + 1);

    // Watchdog loads are one short of the timeout because the entry cycle counts too;
    // the update wait is measured from the pwr_est_end cycle, one cycle before entry.
    localparam logic [WdW-1:0]    WdEst     = WdW'(EST_TO - 1);
    localparam logic [WdW-1:0]    WdUpd     = WdW'(UPD_TO - 2);
    localparam logic [ITER_W-1:0] MaxIter   = ITER_W'(MAX_ITERS);
    localparam logic [ITER_W-1:0] CoarseEnd = ITER_W'(COARSE_ITERS);
    localparam logic [ITER_W-1:0] MedEnd    = ITER_W'(COARSE_ITERS + MED_ITERS);
    localparam logic [ITER_W-1:0] IterSat   = {ITER_W{1'b1}};

    agc_state_e        state_q, state_d;
    logic [ITER_W-1:0] iter_q, iter_d;
    logic              est_start_q, est_start_d;
    logic              fail_q, fail_d;
    logic              relock_q, relock_d;
    logic [1:0]        step_q, step_d;

    logic              settle_load, settle_dec, settle_zero;
    logic              wd_load, wd_dec, wd_zero;
    logic [WdW-1:0]    wd_val;

    agc_dly_cnt #(
        .Width (SETTLE_W)
    ) u_settle_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (agc_stop_i),
        .load_i     (settle_load),
        .load_val_i (settle_cyc_i),
        .dec_i      (settle_dec),
        .zero_o     (settle_zero)
    );

    agc_dly_cnt #(
        .Width (WdW)
    ) u_wd_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (agc_stop_i),
        .load_i     (wd_load),
        .load_val_i (wd_val),
        .dec_i      (wd_dec),
        .zero_o     (wd_zero)
    );

`ifdef AGC_TRACK_EN
    logic             track_load, track_dec, track_zero;
    logic [ERR_W-1:0] trk_err;

    agc_dly_cnt #(
        .Width (TRACK_W)
    ) u_track_cnt (
        .clk_i      (clk_i),
        .reset_i    (reset_i),
        .clr_i      (agc_stop_i),
        .load_i     (track_load),
        .load_val_i (track_period_i),
        .dec_i      (track_dec),
        .zero_o     (track_zero)
    );

    assign trk_err = abs_err(pwr_req_val_i, pwr_est_db_i);
`else
    logic unused_track;
    assign unused_track = ^{track_period_i, relock_th_i, pwr_req_val_i, pwr_est_db_i};
`endif

    always_comb begin
        state_d     = state_q;
        iter_d      = iter_q;
        est_start_d = 1'b0;
        fail_d      = fail_q;
        relock_d    = 1'b0;
        settle_load = 1'b0;
        settle_dec  = 1'b0;
        wd_load     = 1'b0;
        wd_dec      = 1'b0;
        wd_val      = WdEst;
`ifdef AGC_TRACK_EN
        track_load  = 1'b0;
        track_dec   = 1'b0;
`endif
        if (agc_stop_i) begin
            state_d = StIdle;
            iter_d  = '0;
        end else begin
            unique case (state_q)
                StIdle, StFail: begin
                    if (agc_start_i) begin
                        iter_d      = '0;
                        fail_d      = 1'b0;
                        settle_load = 1'b1;
                        state_d     = StSettle;
                    end
                end
                StSettle: begin
                    if (settle_zero) begin
                        est_start_d = 1'b1;
                        wd_load     = 1'b1;
                        wd_val      = WdEst;
                        state_d     = StMeasure;
                    end else begin
                        settle_dec = 1'b1;
                    end
                end
                StMeasure: begin
                    if (pwr_est_end_i) begin
                        if (iter_q != IterSat) begin
                            iter_d = iter_q + ITER_W'(1);
                        end
                        wd_load = 1'b1;
                        wd_val  = WdUpd;
                        state_d = StWaitUpd;
                    end else if (wd_zero) begin
                        fail_d  = 1'b1;
                        state_d = StFail;
                    end else begin
                        wd_dec = 1'b1;
                    end
                end
                StWaitUpd: begin
                    // agc_fix is only meaningful once the PWM update has happened
                    if (pwm_val_up_i || wd_zero) begin
                        if (agc_fix_i) begin
`ifdef AGC_TRACK_EN
                            track_load = 1'b1;
`endif
                            state_d = StLocked;
                        end else if (iter_q == MaxIter) begin
                            fail_d  = 1'b1;
                            state_d = StFail;
                        end else begin
                            settle_load = 1'b1;
                            state_d     = StSettle;
                        end
                    end else begin
                        wd_dec = 1'b1;
                    end
                end
                StLocked: begin
`ifdef AGC_TRACK_EN
                    if (track_period_i != '0) begin
                        if (track_zero) begin
                            est_start_d = 1'b1;
                            wd_load     = 1'b1;
                            wd_val      = WdEst;
                            state_d     = StTrkMeas;
                        end else begin
                            track_dec = 1'b1;
                        end
                    end
`endif
                end
`ifdef AGC_TRACK_EN
                StTrkMeas: begin
                    if (pwr_est_end_i) begin
                        if (trk_err > relock_th_i) begin
                            relock_d    = 1'b1;
                            iter_d      = '0;
                            settle_load = 1'b1;
                            state_d     = StSettle;
                        end else begin
                            track_load = 1'b1;
                            state_d    = StLocked;
                        end
                    end else if (wd_zero) begin
                        fail_d  = 1'b1;
                        state_d = StFail;
                    end else begin
                        wd_dec = 1'b1;
                    end
                end
`endif
                default: state_d = StIdle;
            endcase
        end
    end

    // Step follows the registered iteration count, so it lags iter_cnt by one cycle.
    always_comb begin
        if ((state_q == StLocked) || (state_q == StTrkMeas)) begin
            step_d = STEP_FINE;
        end else if (iter_q < CoarseEnd) begin
            step_d = STEP_COARSE;
        end else if (iter_q < MedEnd) begin
            step_d = STEP_MED;
        end else begin
            step_d = STEP_FINE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            iter_q      <= '0;
            est_start_q <= 1'b0;
            fail_q      <= 1'b0;
            relock_q    <= 1'b0;
            step_q      <= 2'd0;
        end else begin
            state_q     <= state_d;
            iter_q      <= iter_d;
            est_start_q <= est_start_d;
            fail_q      <= fail_d;
            relock_q    <= relock_d;
            step_q      <= step_d;
        end
    end

    assign est_start_o  = est_start_q;
    assign pwm_step_o   = step_q;
    assign agc_fail_o   = fail_q;
    assign agc_relock_o = relock_q;
    assign iter_cnt_o   = iter_q;
    assign agc_locked_o = (state_q == StLocked);
    assign pwm_ena_o    = (state_q == StSettle) || (state_q == StMeasure) ||
                          (state_q == StWaitUpd) || (state_q == StLocked) ||
                          (state_q == StTrkMeas);
    assign agc_busy_o   = (state_q == StSettle) || (state_q == StMeasure) ||
                          (state_q == StWaitUpd) || (state_q == StTrkMeas);

endmodule

// File: tb/tb_agc_loop_seq.sv
// Directed bench for agc_loop_seq with a scoreboard of per-iteration iter_cnt/pwm_step.
// Tracking scenarios run only when AGC_TRACK_EN is defined.
module tb_agc_loop_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        agc_start = 1'b0;
    logic        agc_stop = 1'b0;
    logic [11:0] settle_cyc = 12'd5;
    logic [15:0] track_period = 16'd0;
    logic [8:0]  relock_th = 9'd8;
    logic [8:0]  pwr_req_val = 9'd200;
    logic [8:0]  pwr_est_db = 9'd190;
    logic        pwr_est_end = 1'b0;
    logic        pwm_val_up = 1'b0;
    logic        agc_fix = 1'b0;

    logic        est_start;
    logic        pwm_ena;
    logic [1:0]  pwm_step;
    logic        agc_busy;
    logic        agc_locked;
    logic        agc_fail;
    logic        agc_relock;
    logic [5:0]  iter_cnt;

    int total = 0;
    int bad = 0;

    typedef struct packed {
        logic [5:0] iter;
        logic [1:0] step;
    } exp_t;

    exp_t sb_q[$];

    agc_loop_seq u_dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .agc_start_i    (agc_start),
        .agc_stop_i     (agc_stop),
        .settle_cyc_i   (settle_cyc),
        .track_period_i (track_period),
        .relock_th_i    (relock_th),
        .pwr_req_val_i  (pwr_req_val),
        .pwr_est_db_i   (pwr_est_db),
        .pwr_est_end_i  (pwr_est_end),
        .pwm_val_up_i   (pwm_val_up),
        .agc_fix_i      (agc_fix),
        .est_start_o    (est_start),
        .pwm_ena_o      (pwm_ena),
        .pwm_step_o     (pwm_step),
        .agc_busy_o     (agc_busy),
        .agc_locked_o   (agc_locked),
        .agc_fail_o     (agc_fail),
        .agc_relock_o   (agc_relock),
        .iter_cnt_o     (iter_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [1:0] step_of(input int k);
        return (k < 8) ? 2'd3 : ((k < 24) ? 2'd2 : 2'd1);
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_est(input string tag, input int limit, output int n);
        n = 0;
        while (est_start !== 1'b1 && n < limit) begin
            tick(1);
            n++;
        end
        chk({tag, "_est_seen"}, 32'(est_start), 1);
    endtask

    task automatic sb_check(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            chk({tag, "_sb_nonempty"}, 32'(sb_q.size()), 1);
            return;
        end
        e = sb_q.pop_front();
        chk({tag, "_iter"}, 32'(iter_cnt), 32'(e.iter));
        chk({tag, "_step"}, 32'(pwm_step), 32'(e.step));
    endtask

    // One acquisition iteration: est_end 10 cycles after est_start, pwm_val_up 2 later.
    task automatic run_iter(input int k, input bit fix, input int lat_exp, input string tag);
        int n;
        wait_est(tag, 2000, n);
        if (lat_exp >= 0) chk({tag, "_lat"}, 32'(n), 32'(lat_exp));
        sb_check(tag);
        tick(10);
        pwr_est_end = 1'b1;
        tick(1);
        pwr_est_end = 1'b0;
        if (k + 1 < 48 && !fix) sb_q.push_back('{iter: 6'(k + 1), step: step_of(k + 1)});
        tick(1);
        pwm_val_up = 1'b1;
        agc_fix = fix;
        tick(1);
        pwm_val_up = 1'b0;
    endtask

    task automatic do_start();
        agc_start = 1'b1;
        tick(1);
        agc_start = 1'b0;
    endtask

    task automatic do_stop();
        agc_stop = 1'b1;
        tick(1);
        agc_stop = 1'b0;
    endtask

    initial begin
        int n;
        int n_est;

        // reset values
        tick(2);
        chk("rst_est", 32'(est_start), 0);
        chk("rst_ena", 32'(pwm_ena), 0);
        chk("rst_step", 32'(pwm_step), 0);
        chk("rst_busy", 32'(agc_busy), 0);
        chk("rst_locked", 32'(agc_locked), 0);
        chk("rst_fail", 32'(agc_fail), 0);
        chk("rst_relock", 32'(agc_relock), 0);
        chk("rst_iter", 32'(iter_cnt), 0);
        reset = 1'b0;
        tick(1);

        // lock on the 3rd iteration
        sb_q.push_back('{iter: 6'd0, step: 2'd3});
        do_start();
        chk("t1_busy", 32'(agc_busy), 1);
        chk("t1_ena", 32'(pwm_ena), 1);
        for (int k = 0; k < 3; k++) run_iter(k, k == 2, 6, "t1");
        chk("t1_locked", 32'(agc_locked), 1);
        chk("t1_busy_lk", 32'(agc_busy), 0);
        chk("t1_iter", 32'(iter_cnt), 3);
        chk("t1_ena_lk", 32'(pwm_ena), 1);
        tick(1);
        chk("t1_step_lk", 32'(pwm_step), 1);
        n_est = 0;
        for (int i = 0; i < 150; i++) begin
            tick(1);
            if (est_start === 1'b1) n_est++;
        end
        chk("t1_no_est_after_lock", 32'(n_est), 0);
        chk("t1_still_locked", 32'(agc_locked), 1);
        agc_start = 1'b1;
        tick(1);
        agc_start = 1'b0;
        chk("t1_start_ignored", 32'(agc_locked), 1);

        // full acquisition without fix -> FAIL after 48 updates
        do_stop();
        agc_fix = 1'b0;
        chk("stop_busy", 32'(agc_busy), 0);
        chk("stop_ena", 32'(pwm_ena), 0);
        chk("stop_iter", 32'(iter_cnt), 0);
        sb_q.push_back('{iter: 6'd0, step: 2'd3});
        do_start();
        for (int k = 0; k < 48; k++) run_iter(k, 1'b0, 6, "acq");
        chk("acq_fail", 32'(agc_fail), 1);
        chk("acq_ena", 32'(pwm_ena), 0);
        chk("acq_busy", 32'(agc_busy), 0);
        chk("acq_iter", 32'(iter_cnt), 48);

        // estimate watchdog
        sb_q.push_back('{iter: 6'd0, step: 2'd3});
        do_start();
        chk("est_to_fail_clr", 32'(agc_fail), 0);
        wait_est("est_to", 100, n);
        sb_check("est_to");
        n = 0;
        while (agc_fail !== 1'b1 && n < 1100) begin
            tick(1);
            n++;
        end
        chk("est_to_cycles", 32'(n), 1023);
        chk("est_to_ena", 32'(pwm_ena), 0);

        // stop in FAIL keeps agc_fail
        do_stop();
        chk("stop_fail_kept", 32'(agc_fail), 1);

        // update watchdog
        sb_q.push_back('{iter: 6'd0, step: 2'd3});
        do_start();
        wait_est("upd_to", 100, n);
        sb_check("upd_to");
        tick(3);
        pwr_est_end = 1'b1;
        tick(1);
        pwr_est_end = 1'b0;
        sb_q.push_back('{iter: 6'd1, step: 2'd3});
        wait_est("upd_to2", 100, n);
        chk("upd_to_lat", 32'(n), 4 + 5 + 1 - 1);
        sb_check("upd_to2");

        // stop + start together in MEASURE
        agc_stop = 1'b1;
        agc_start = 1'b1;
        tick(1);
        agc_stop = 1'b0;
        agc_start = 1'b0;
        chk("ss_busy", 32'(agc_busy), 0);
        chk("ss_ena", 32'(pwm_ena), 0);
        chk("ss_est", 32'(est_start), 0);
        chk("ss_iter", 32'(iter_cnt), 0);
        tick(3);
        chk("ss_idle_held", 32'(pwm_ena), 0);

`ifdef AGC_TRACK_EN
        // tracking: relock on large error, return to LOCKED on small error
        track_period = 16'd100;
        relock_th = 9'd8;
        pwr_req_val = 9'd200;
        pwr_est_db = 9'd190;
        sb_q.push_back('{iter: 6'd0, step: 2'd3});
        do_start();
        run_iter(0, 1'b1, 6, "trk0");
        chk("trk0_locked", 32'(agc_locked), 1);
        wait_est("trk_meas1", 300, n);
        chk("trk_period1", 32'(n), 101);
        tick(3);
        pwr_est_end = 1'b1;
        tick(1);
        pwr_est_end = 1'b0;
        agc_fix = 1'b0;
        chk("relock_pulse", 32'(agc_relock), 1);
        chk("relock_iter", 32'(iter_cnt), 0);
        chk("relock_busy", 32'(agc_busy), 1);
        chk("relock_unlocked", 32'(agc_locked), 0);
        sb_q.push_back('{iter: 6'd0, step: 2'd3});
        tick(1);
        chk("relock_pulse_end", 32'(agc_relock), 0);
        chk("relock_step", 32'(pwm_step), 3);
        pwr_est_db = 9'd195;
        run_iter(0, 1'b1, 5, "trk1");
        chk("trk1_locked", 32'(agc_locked), 1);
        wait_est("trk_meas2", 300, n);
        chk("trk_period2", 32'(n), 101);
        tick(3);
        pwr_est_end = 1'b1;
        tick(1);
        pwr_est_end = 1'b0;
        chk("trk_stay_locked", 32'(agc_locked), 1);
        chk("trk_no_relock", 32'(agc_relock), 0);
        wait_est("trk_meas3", 300, n);
        chk("trk_period3", 32'(n), 101);
        do_stop();
        agc_fix = 1'b0;
        track_period = 16'd0;
`endif

        // reset in SETTLE
        do_start();
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("rs_est", 32'(est_start), 0);
        chk("rs_ena", 32'(pwm_ena), 0);
        chk("rs_step", 32'(pwm_step), 0);
        chk("rs_busy", 32'(agc_busy), 0);
        chk("rs_locked", 32'(agc_locked), 0);
        chk("rs_fail", 32'(agc_fail), 0);
        chk("rs_relock", 32'(agc_relock), 0);
        chk("rs_iter", 32'(iter_cnt), 0);
        reset = 1'b0;
        tick(2);

        chk("sb_drained", 32'(sb_q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/agc_loop_seq.md
Name: agc_loop_seq

Overview:
Sequencer for the AGC gain loop that drives pwm_gen and the power estimator. Each iteration it waits a programmable settle time after a PWM update, requests a power estimate, waits for the PWM update, and schedules the PWM step size from coarse to fine. It declares lock, times out, and optionally keeps tracking with periodic re-measurement and relock. Sits between the AGC register block and the pwm_gen / power-estimator pair.

Parameters:
SETTLE_W, 12, width of settle_cyc and the settle counter
TRACK_W, 16, width of track_period and the tracking counter
ITER_W, 6, width of iter_cnt
COARSE_ITERS, 8, iterations using step 3
MED_ITERS, 16, further iterations using step 2; step 1 after that
MAX_ITERS, 48, iteration limit before FAIL (must be < 2^ITER_W)
EST_TO, 1023, watchdog cycles waiting for pwr_est_end
UPD_TO, 4, watchdog cycles waiting for pwm_val_up

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
agc_start  in  1  one-cycle start pulse
agc_stop  in  1  abort to IDLE; level, highest priority
settle_cyc  in  SETTLE_W  settle cycles after each PWM update
track_period  in  TRACK_W  cycles between tracking measurements
relock_th  in  9  |pwr_req_val - pwr_est_dB| threshold for relock (0.125 dB LSB)
pwr_req_val  in  9  target power, dB
pwr_est_dB  in  9  estimated power, valid with pwr_est_end
pwr_est_end  in  1  estimate-done pulse
pwm_val_up  in  1  pwm_gen update pulse, 2 cycles after pwr_est_end
agc_fix  in  1  pwm_gen sticky fix flag
est_start  out  1  one-cycle estimate request
pwm_ena  out  1  to pwm_gen
pwm_step  out  2  to pwm_gen
agc_busy  out  1  state is not IDLE, LOCKED or FAIL
agc_locked  out  1  state is LOCKED
agc_fail  out  1  sticky until next agc_start or reset
agc_relock  out  1  one-cycle pulse on relock
iter_cnt  out  ITER_W  completed iterations

Behaviour:
- Reset: state IDLE; all outputs 0; counters 0.
- States: IDLE, SETTLE, MEASURE, WAIT_UPD, LOCKED, TRK_MEAS, FAIL.
- pwm_ena = 1 in SETTLE, MEASURE, WAIT_UPD, LOCKED and TRK_MEAS; 0 in IDLE and FAIL, so pwm_gen loads its preset value.
- IDLE: on agc_start, clear iter_cnt and agc_fail, load settle_cnt with settle_cyc, and go to SETTLE.
- SETTLE: decrement settle_cnt each cycle. At 0, pulse est_start for one cycle and go to MEASURE. settle_cyc=0 gives one cycle in SETTLE.
- MEASURE: on pwr_est_end, iter_cnt++ (saturating) and go to WAIT_UPD. If EST_TO cycles pass without pwr_est_end, set agc_fail and go to FAIL.
- WAIT_UPD: on pwm_val_up, or after UPD_TO cycles:
  - agc_fix=1: go to LOCKED.
  - else iter_cnt==MAX_ITERS: set agc_fail and go to FAIL.
  - else reload settle_cnt and go to SETTLE.
  - agc_fix is sampled in this state because it is valid only once pwm_val_up arrives.
- pwm_step:
  - iter_cnt < COARSE_ITERS: 3.
  - iter_cnt < COARSE_ITERS+MED_ITERS: 2.
  - otherwise, and in LOCKED/TRK_MEAS: 1.
  - Registered, so it changes the cycle after iter_cnt changes.
- LOCKED: load track_cnt with track_period on entry. At 0, pulse est_start and go to TRK_MEAS. track_period=0 disables tracking (stay in LOCKED).
- TRK_MEAS: on pwr_est_end, compute abs error with 10-bit signed subtraction.
  - error > relock_th: pulse agc_relock, clear iter_cnt, reload settle_cnt, go to SETTLE (coarse steps resume).
  - otherwise: return to LOCKED.
  - EST_TO expiry: go to FAIL.
- FAIL: hold. agc_start restarts exactly as from IDLE.
- agc_start in any other state is ignored.
- agc_stop: any state goes to IDLE next cycle; counters clear; agc_fail is kept. If agc_stop and agc_start coincide, agc_stop wins.
- Reset mid-operation: returns to IDLE in the same edge; est_start is never left high.

Optional Feature:
AGC_TRACK_EN.
- Defined: LOCKED/TRK_MEAS tracking, track_period and relock_th are functional.
- Undefined: LOCKED is terminal; no est_start is issued after lock; agc_relock ties to 0; track_period and relock_th are unused; TRK_MEAS does not exist.

Decomposition:
- Package agc_seq_pkg holds:
  - state encoding constants (3 bits);
  - step constants STEP_COARSE=3, STEP_MED=2, STEP_FINE=1;
  - abs-error width 9.
- Sub-module agc_dly_cnt: loadable, parameterized-width down counter with a zero flag. Instantiated for settle, track and the shared watchdog.

Test Plan:
- settle_cyc=5, pwr_est_end 10 cycles after est_start, agc_fix rising on the 3rd iteration -> est_start 6 cycles after each entry to SETTLE; LOCKED after iteration 3; iter_cnt=3; pwm_step=3 throughout acquisition.
- agc_fix never set, MAX_ITERS=48 -> pwm_step 3 for iterations 0-7, 2 for 8-23, 1 for 24-47; FAIL after the 48th update; pwm_ena=0; agc_fail=1.
- pwr_est_end withheld -> FAIL exactly EST_TO cycles after est_start.
- pwm_val_up withheld -> SETTLE entered UPD_TO cycles after pwr_est_end.
- Tracking (AGC_TRACK_EN), track_period=100, relock_th=8, pwr_req=200, est=190 -> agc_relock pulse; SETTLE entered with iter_cnt=0 and pwm_step=3. With est=195 -> back to LOCKED.
- agc_stop asserted in MEASURE together with agc_start -> IDLE next cycle; pwm_ena=0; est_start=0; reset asserted in SETTLE -> all outputs 0 next cycle.
